// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the instruction fetch path
package core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush and occupancy count
module fetch_fifo
    import core_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = if_entry_t
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  T                           i_push_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = i_pop && (count_q != '0);
        // a full FIFO still takes a push when the head leaves in the same cycle
        do_push  = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: imem request issue, response buffering, redirect and drop
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_vld,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_req_rdy,
    input  logic        i_imem_rsp_vld,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_if_vld,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    input  logic        i_id_rdy,
    output logic        o_redirect_misalign
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = CNT_W + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             misalign_q, misalign_d;

    logic [CNT_W-1:0] pcq_count, buf_count;
    logic [31:0]      pcq_head;
    if_entry_t        buf_head, buf_push_data;
    logic [OUT_W-1:0] outstanding;
    logic             req_fire, rsp_ok, rsp_keep, buf_pop;

    // in-flight = responses still to be dropped plus PCs waiting for their word
    assign outstanding = OUT_W'(drop_cnt_q) + OUT_W'(pcq_count);

    always_comb begin
        o_imem_req_vld = (state_q == ST_RUN) && !i_redirect &&
                         ((outstanding + OUT_W'(buf_count)) < OUT_W'(DEPTH));
        req_fire       = o_imem_req_vld && i_imem_req_rdy;
        rsp_ok         = i_imem_rsp_vld && (outstanding != '0);
        rsp_keep       = rsp_ok && (drop_cnt_q == '0) && !i_redirect;
        buf_pop        = o_if_vld && i_id_rdy;
        buf_push_data  = '{pc: pcq_head, instr: i_imem_rsp_data};
    end

    always_comb begin
        state_d    = ST_RUN;
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        misalign_d = i_redirect && (i_redirect_pc[1:0] != 2'b00);
        if (i_redirect) begin
            fetch_pc_d = align_word(i_redirect_pc);
            // everything still in flight becomes stale, minus a response landing now
            drop_cnt_d = drop_cnt_q + pcq_count - CNT_W'(rsp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_ok && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_pc_queue (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_redirect),
        .i_push      (req_fire),
        .i_push_data (fetch_pc_q),
        .i_pop       (rsp_keep),
        .o_head      (pcq_head),
        .o_count     (pcq_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(if_entry_t)) u_if_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_redirect),
        .i_push      (rsp_keep),
        .i_push_data (buf_push_data),
        .i_pop       (buf_pop),
        .o_head      (buf_head),
        .o_count     (buf_count)
    );

    assign o_imem_addr         = fetch_pc_q;
    assign o_if_vld            = (buf_count != '0);
    assign o_if_pc             = o_if_vld ? buf_head.pc : 32'h0;
    assign o_if_instr          = o_if_vld ? buf_head.instr : NOP_INSTR;
    assign o_redirect_misalign = misalign_q;

    rsp_without_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_imem_rsp_vld && (outstanding == '0)));

endmodule
